prog_loader: RTL and testbench
==============================

Name: prog_loader

Overview:
Writes a program image into the CPU instruction memory, which the CPU only ever reads. The image arrives as a framed byte stream over a valid/ready interface. Each instruction is assembled from two bytes and written to consecutive addresses starting at 0. The CPU is held in reset until a complete frame passes its checksum.

Parameters:
ADDR_SIZE, 8, instruction-memory address width
INST_SIZE, 16, instruction width; fixed at 2 bytes (hi byte first)
SYNC_BYTE, 8'hA5, frame start marker

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-high
rx_data  input  8  incoming byte
rx_valid  input  1  rx_data valid; byte accepted when rx_valid && rx_ready at posedge clk
rx_ready  output  1  loader can accept a byte this cycle
mem_addr  output  ADDR_SIZE  instruction memory write address
mem_data  output  INST_SIZE  instruction memory write data
mem_we  output  1  instruction memory write enable, one-cycle pulse
cpu_hold  output  1  drives CPU rst; 1 = CPU held in reset
done  output  1  program loaded and verified
error  output  1  last frame failed checksum

Behaviour:
- Frame format: SYNC_BYTE, LEN, then 2*N payload bytes (hi, lo per instruction), then CHK.
- N = LEN; LEN=0 means 256 instructions.
- CHK = XOR of LEN and all payload bytes (SYNC excluded).
- Counter is ADDR_SIZE+1 bits wide. mem_addr wraps modulo 2^ADDR_SIZE.
- States and transitions:
  - SYNC: rx_ready=1. Accepting SYNC_BYTE -> LEN. Any other byte is discarded; stay in SYNC.
  - LEN: accept byte; latch N; chk=byte; addr=0 -> HI.
  - HI: accept byte; latch hi; chk^=byte -> LO.
  - LO: accept byte; latch lo; chk^=byte -> WR.
  - WR: rx_ready=0.
    - mem_we=1, mem_addr=addr, mem_data={hi,lo}, all registered outputs valid this cycle.
    - Then addr+=1, count+=1.
    - If count reaches N -> CHK, else -> HI.
  - CHK: accept byte.
    - byte==chk -> DONE.
    - byte!=chk -> ERR.
  - DONE: rx_ready=0, done=1, cpu_hold=0. Stays until rst.
  - ERR: rx_ready=1, error=1, cpu_hold=1.
    - Accepting SYNC_BYTE -> LEN and clears error.
    - Other bytes are discarded.
- mem_we is high only in WR: exactly one cycle per instruction, never two consecutive cycles.
- Memory contents written before an error are not rolled back; the CPU stays held.
- No byte is accepted when rx_valid=0. State holds while stalled; rx_valid may drop mid-frame for any number of cycles.
- Reset values (async, immediate on rst):
  - state=SYNC, rx_ready=1 after reset deasserts.
  - mem_we=0, mem_addr=0, mem_data=0.
  - cpu_hold=1, done=0, error=0.
  - Internal counters and chk = 0.
- rst mid-frame aborts the frame. A partial image remains in memory; the next load starts at SYNC.
- SYNC_BYTE inside payload, LEN or CHK is treated as ordinary data; it does not resynchronize.
- cpu_hold is 1 in every state except DONE.

Test Plan:
- Frame A5 02 12 34 56 78 0A, rx_valid held 1 -> writes addr0=0x1234, addr1=0x5678, each a one-cycle mem_we; then done=1, cpu_hold=0, rx_ready=0.
- Same frame with CHK=0x0B -> both writes occur, then error=1, cpu_hold=1, done=0. Following frame A5 01 00 FF FE -> error clears, addr0=0x00FF, done=1.
- Garbage 00 FF 5A before A5 01 AB CD 67 -> garbage ignored, no mem_we; addr0=0xABCD, done=1.
- LEN=00 with 512 payload bytes (inst i = {i, ~i}, CHK=0x00) -> 256 writes at addr 0..255 with correct data, then done=1; no write after addr 255.
- rx_valid toggled randomly (about 50%) during the first frame -> identical writes and result, with no duplicate or lost bytes.
- Assert rst after the first payload pair of A5 02 ... -> immediate return to reset values. Restarting with a full valid frame loads correctly from addr 0.

Source files
------------

// File: rtl/prog_loader.sv
// prog_loader: loads a framed, XOR-checked byte stream into instruction memory
// and releases the CPU from reset only after a clean frame.
module prog_loader #(
   parameter int          ADDR_SIZE = 8,
   parameter int          INST_SIZE = 16,
   parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [7:0]           rx_data,
   input  logic                 rx_valid,
   output logic                 rx_ready,
   output logic [ADDR_SIZE-1:0] mem_addr,
   output logic [INST_SIZE-1:0] mem_data,
   output logic                 mem_we,
   output logic                 cpu_hold,
   output logic                 done,
   output logic                 error
);
   localparam int NW = ADDR_SIZE + 1;
   typedef enum logic [2:0] {S_SYNC, S_LEN, S_HI, S_LO, S_WR, S_CHK, S_DONE, S_ERR} state_t;
   state_t state, nxt;
   logic [NW-1:0]        n, count, count_nx, len_n;
   logic [ADDR_SIZE-1:0] addr;
   logic [7:0]           hi, lo, chk;
   logic                 acc;
   assign acc      = rx_valid && rx_ready;
   assign count_nx = count + 1'b1;
   // LEN of zero encodes a full 256-instruction image
   assign len_n    = (rx_data == 8'd0) ? NW'(256) : NW'(rx_data);
   assign rx_ready = !(state inside {S_WR, S_DONE});
   assign mem_we   = state == S_WR;
   assign mem_addr = addr;
   assign mem_data = {hi, lo};
   assign cpu_hold = state != S_DONE;
   assign done     = state == S_DONE;
   assign error    = state == S_ERR;
   always_comb begin
      nxt = state;
      case (state)
         S_SYNC, S_ERR: nxt = (acc && rx_data == SYNC_BYTE) ? S_LEN : state;
         S_LEN:         nxt = acc ? S_HI : state;
         S_HI:          nxt = acc ? S_LO : state;
         S_LO:          nxt = acc ? S_WR : state;
         S_WR:          nxt = (count_nx == n) ? S_CHK : S_HI;
         S_CHK:         nxt = acc ? ((rx_data == chk) ? S_DONE : S_ERR) : state;
         default:       nxt = state;
      endcase
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_SYNC;
         n     <= '0;
         count <= '0;
         addr  <= '0;
         hi    <= '0;
         lo    <= '0;
         chk   <= '0;
      end else begin
         state <= nxt;
         if (state == S_LEN && acc) begin
            n     <= len_n;
            chk   <= rx_data;
            addr  <= '0;
            count <= '0;
         end
         if (state == S_HI && acc) begin
            hi  <= rx_data;
            chk <= chk ^ rx_data;
         end
         if (state == S_LO && acc) begin
            lo  <= rx_data;
            chk <= chk ^ rx_data;
         end
         if (state == S_WR) begin
            addr  <= addr + 1'b1;
            count <= count_nx;
         end
      end
   end
endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: randomized frames against a queue-based reference model;
// a monitor pops expected writes whenever mem_we is seen.
module tb_prog_loader;
   logic        clk = 0, rst = 1, rx_valid = 0;
   logic [7:0]  rx_data = 0;
   logic        rx_ready, mem_we, cpu_hold, done, error;
   logic [7:0]  mem_addr;
   logic [15:0] mem_data;
   int checks = 0, errors = 0;
   typedef struct packed {logic [7:0] a; logic [15:0] d;} wr_t;
   wr_t        exp_q[$];
   logic [7:0] pl[$];
   logic       prev_we = 0;

   prog_loader dut (.clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
      .rx_ready(rx_ready), .mem_addr(mem_addr), .mem_data(mem_data), .mem_we(mem_we),
      .cpu_hold(cpu_hold), .done(done), .error(error));

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      wr_t e;
      if (!rst && mem_we) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write: addr %0h data %0h with no write expected", mem_addr, mem_data);
         end else begin
            e = exp_q.pop_front();
            check("wr_addr", mem_addr, e.a);
            check("wr_data", mem_data, e.d);
         end
         check("we_not_back_to_back", prev_we, 0);
      end
      prev_we <= rst ? 1'b0 : mem_we;
   end

   task automatic check_reset();
      check("rst_mem_we", mem_we, 0);
      check("rst_mem_addr", mem_addr, 0);
      check("rst_mem_data", mem_data, 0);
      check("rst_cpu_hold", cpu_hold, 1);
      check("rst_done", done, 0);
      check("rst_error", error, 0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1;
      rx_valid = 0;
      repeat (2) @(negedge clk);
      check_reset();
      rst = 0;
      check("rx_ready_after_rst", rx_ready, 1);
   endtask

   task automatic send(input logic [7:0] b, input bit jit);
      int t = 0;
      if (jit)
         while ($urandom_range(1) == 1) begin
            rx_valid = 0;
            rx_data = 8'($urandom);
            @(negedge clk);
         end
      rx_data = b;
      rx_valid = 1;
      while (!rx_ready) begin
         @(negedge clk);
         if (++t > 1000) begin
            checks++;
            errors++;
            $display("FAIL rx_ready_timeout: byte %0h never accepted", b);
            rx_valid = 0;
            return;
         end
      end
      @(negedge clk);
      rx_valid = 0;
   endtask

   task automatic wait_result(input bit ok);
      int t = 0;
      while (!(done || error) && t < 100) begin
         @(negedge clk);
         t++;
      end
      check("done", done, ok);
      check("error", error, !ok);
      check("cpu_hold", cpu_hold, !ok);
      check("rx_ready_end", rx_ready, !ok);
      check("writes_drained", exp_q.size(), 0);
   endtask

   // Reference model: every instruction is the next byte pair, written at its index mod 256
   task automatic frame(input logic [7:0] len, input bit bad, input bit jit);
      int n = (len == 0) ? 256 : int'(len);
      logic [7:0] c = len;
      wr_t w;
      for (int i = 0; i < n; i++) begin
         w.a = i[7:0];
         w.d = {pl[2*i], pl[2*i+1]};
         exp_q.push_back(w);
         c ^= pl[2*i] ^ pl[2*i+1];
      end
      if (bad) c ^= 8'h01;
      send(8'hA5, jit);
      send(len, jit);
      foreach (pl[i]) send(pl[i], jit);
      send(c, jit);
      wait_result(!bad);
   endtask

   initial begin
      logic [7:0] len;
      int n;
      wr_t w;
      rst = 1;
      repeat (2) @(negedge clk);
      check_reset();
      rst = 0;
      check("rx_ready_after_rst", rx_ready, 1);
      pl = {8'h12, 8'h34, 8'h56, 8'h78};
      frame(8'd2, 0, 0);
      do_reset();
      frame(8'd2, 1, 0);
      pl = {8'h00, 8'hFF};
      frame(8'd1, 0, 0);
      do_reset();
      send(8'h00, 0);
      send(8'hFF, 0);
      send(8'h5A, 0);
      pl = {8'hAB, 8'hCD};
      frame(8'd1, 0, 0);
      do_reset();
      pl = {};
      for (int i = 0; i < 256; i++) begin
         pl.push_back(i[7:0]);
         pl.push_back(~i[7:0]);
      end
      frame(8'd0, 0, 0);
      do_reset();
      pl = {8'hA5, 8'hA5, 8'hA5, 8'hA5};
      frame(8'd2, 0, 0);
      do_reset();
      pl = {8'h12, 8'h34, 8'h56, 8'h78};
      frame(8'd2, 0, 1);
      for (int k = 0; k < 8; k++) begin
         do_reset();
         len = 8'($urandom);
         n = (len == 0) ? 256 : int'(len);
         pl = {};
         for (int i = 0; i < 2 * n; i++) pl.push_back(8'($urandom));
         frame(len, $urandom_range(1) == 1, 1);
      end
      do_reset();
      w.a = 8'h00;
      w.d = 16'h1234;
      exp_q.push_back(w);
      send(8'hA5, 0);
      send(8'h02, 0);
      send(8'h12, 0);
      send(8'h34, 0);
      @(negedge clk);
      #2 rst = 1;
      #1 check_reset();
      check("partial_write_seen", exp_q.size(), 0);
      @(negedge clk);
      rst = 0;
      pl = {8'h12, 8'h34, 8'h56, 8'h78};
      frame(8'd2, 0, 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
endmodule
